// File: rtl/_demux8_reg_pkg.sv
// Shared constants, select type, FSM encodings and the one-hot helper used by
// the 8-way distribution datapath.
package constants;

    localparam int WORD_LENGTH = 32;
    localparam int DEMUX8_WAYS = 8;

    typedef logic [2:0] sel8_t;

    // Holding-register state, derived from the owed-channel mask
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    function automatic logic [DEMUX8_WAYS-1:0] onehot8(input sel8_t s);
        logic [DEMUX8_WAYS-1:0] m;
        m    = '0;
        m[s] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/_demux8_reg_dec3to8.sv
// Purpose: 3-to-8 one-hot decoder from a channel select to a channel mask.
// Latency: combinational.
// Backpressure: none; pure function of sel.
module _dec3to8
    import constants::*;
(
    input  sel8_t                  sel,
    output logic [DEMUX8_WAYS-1:0] mask
);

    assign mask = onehot8(sel);

endmodule

// File: rtl/_demux8_reg.sv
// Purpose: registered 1-to-8 demux; one held word owed to the channels in pend_q.
// Latency: word accepted at edge k is valid on its channel from cycle k+1.
// Backpressure: in_ready drops combinationally while any owed channel has out_ready low.
// Build option: DEMUX8_BROADCAST_EN adds the bcast port (load all eight channels).
module _demux8_reg
    import constants::*;
#(
    parameter int n = WORD_LENGTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  sel8_t                  sel,
    input  logic [n-1:0]           in,
`ifdef DEMUX8_BROADCAST_EN
    input  logic                   bcast,
`endif
    output logic [n-1:0]           out [DEMUX8_WAYS-1:0],
    output logic [DEMUX8_WAYS-1:0] out_valid,
    input  logic [DEMUX8_WAYS-1:0] out_ready
);

    logic [n-1:0]           data_q;
    logic [DEMUX8_WAYS-1:0] pend_q;
    logic [DEMUX8_WAYS-1:0] drain;
    logic [DEMUX8_WAYS-1:0] sel_mask;
    logic [DEMUX8_WAYS-1:0] load_mask;
    logic [0:0]             state;
    logic                   accept;

    _dec3to8 u_dec (
        .sel  (sel),
        .mask (sel_mask)
    );

`ifdef DEMUX8_BROADCAST_EN
    assign load_mask = bcast ? {DEMUX8_WAYS{1'b1}} : sel_mask;
`else
    assign load_mask = sel_mask;
`endif

    assign state = (pend_q == '0) ? ST_EMPTY : ST_HOLD;

    // Channels still owed after this cycle; a reload is allowed as soon as none remain,
    // which lets the last drain and the next accept share one edge.
    assign drain    = pend_q & ~out_ready;
    assign in_ready = (state == ST_EMPTY) || (drain == '0);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            data_q <= '0;
        end else if (accept) begin
            pend_q <= load_mask;
            data_q <= in;
        end else begin
            pend_q <= drain;
        end
    end

    assign out_valid = pend_q;

    for (genvar i = 0; i < DEMUX8_WAYS; i++) begin : g_out
        assign out[i] = pend_q[i] ? data_q : '0;
    end

endmodule

// File: tb/tb__demux8_reg.sv
// Randomised and directed bench for _demux8_reg against a per-channel delivery model.
module tb__demux8_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  sel_d;
    logic [31:0] in_d;
    logic        bcast_d;
    logic [31:0] out_d [7:0];
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: which channels are still owed a word, and which word each is owed.
    bit          owed [8];
    logic [31:0] owed_word [8];
    logic [7:0]  exp_valid;
    logic [31:0] exp_out [8];
    logic        exp_rdy;

    always #5 clk = ~clk;

    _demux8_reg #(.n(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel_d),
        .in        (in_d),
`ifdef DEMUX8_BROADCAST_EN
        .bcast     (bcast_d),
`endif
        .out       (out_d),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            owed[i]      = 1'b0;
            owed_word[i] = '0;
        end
    endtask

    task automatic model_eval();
        exp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_valid[i] = owed[i];
            exp_out[i]   = owed[i] ? owed_word[i] : 32'h0;
            if (owed[i] && !out_ready[i]) exp_rdy = 1'b0;
        end
    endtask

    // Drive inputs just after a falling edge and settle combinational outputs.
    task automatic drive(input bit v, input logic [2:0] s, input logic [31:0] d,
                         input bit b, input logic [7:0] rdy);
        in_valid  = v;
        sel_d     = s;
        in_d      = d;
`ifdef DEMUX8_BROADCAST_EN
        bcast_d   = b;
`else
        bcast_d   = 1'b0 & b;
`endif
        out_ready = rdy;
        #1;
        model_eval();
    endtask

    // Apply this cycle's handshakes to the model, then move to the next falling edge.
    task automatic advance();
        bit acc;
        model_eval();
        acc = in_valid && exp_rdy && rst_n;
        for (int i = 0; i < 8; i++)
            if (owed[i] && out_ready[i]) owed[i] = 1'b0;
        if (acc) begin
            for (int i = 0; i < 8; i++) begin
                if (bcast_d || (sel_d == i[2:0])) begin
                    owed[i]      = 1'b1;
                    owed_word[i] = in_d;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 3'd0, 32'h0, 0, 8'hFF);
        model_clear();
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 8'h00) begin n_bad++; $display("FAIL reset_valid got=%h want=00", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b want=1", in_ready); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (out_d[i] !== 32'h0) begin n_bad++; $display("FAIL reset_out%0d got=%h want=0", i, out_d[i]); end
        end
        rst_n = 1'b1;
        @(negedge clk);
        // Hold a word on channel 4, then reset asynchronously mid-HOLD
        drive(1, 3'd4, 32'hCAFE0004, 0, 8'hEF);
        advance();
        drive(0, 3'd0, 32'h0, 0, 8'hEF);
        n_cmp++;
        if (out_valid !== 8'h10) begin n_bad++; $display("FAIL hold4_valid got=%h want=10", out_valid); end
        rst_n = 1'b0;
        #1;
        model_clear();
        n_cmp++;
        if (out_valid !== 8'h00) begin n_bad++; $display("FAIL async_reset_valid got=%h want=00", out_valid); end
        n_cmp++;
        if (out_d[4] !== 32'h0) begin n_bad++; $display("FAIL async_reset_out4 got=%h want=0", out_d[4]); end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 3'd0, 32'h0, 0, 8'hFF);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got=%b want=1", in_ready); end
        advance();
        n_cmp++;
        if (out_valid !== 8'h00) begin n_bad++; $display("FAIL no_replay got=%h want=00", out_valid); end
    endtask

    task automatic test_single_route();
        drive(1, 3'd5, 32'hDEADBEEF, 0, 8'hFF);
        advance();
        drive(0, 3'd0, 32'h0, 0, 8'hFF);
        n_cmp++;
        if (out_valid !== 8'h20) begin n_bad++; $display("FAIL route_valid got=%h want=20", out_valid); end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (out_d[i] !== ((i == 5) ? 32'hDEADBEEF : 32'h0)) begin
                n_bad++; $display("FAIL route_out%0d got=%h", i, out_d[i]);
            end
        end
        advance();
    endtask

    task automatic test_streaming();
        logic [31:0] words [16];
        for (int k = 0; k < 16; k++) words[k] = $urandom;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) drive(1, k[2:0], words[k], 0, 8'hFF);
            else        drive(0, 3'd0, 32'h0, 0, 8'hFF);
            n_cmp++;
            if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready k=%0d got=%b want=1", k, in_ready); end
            if (k > 0) begin
                n_cmp++;
                if (out_valid !== (8'h01 << ((k - 1) % 8))) begin
                    n_bad++; $display("FAIL stream_valid k=%0d got=%h", k, out_valid);
                end
                n_cmp++;
                if (out_d[(k - 1) % 8] !== words[k - 1]) begin
                    n_bad++; $display("FAIL stream_data k=%0d got=%h want=%h", k, out_d[(k - 1) % 8], words[k - 1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] w;
        logic [31:0] x;
        w = $urandom;
        x = $urandom;
        drive(1, 3'd3, w, 0, 8'hFF);
        advance();
        for (int c = 0; c < 4; c++) begin
            drive(1, 3'($urandom_range(0, 7)), $urandom, 0, 8'hF7);
            n_cmp++;
            if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready c=%0d got=%b want=0", c, in_ready); end
            n_cmp++;
            if (out_valid !== 8'h08 || out_d[3] !== w) begin
                n_bad++; $display("FAIL bp_hold c=%0d got=%h/%h want=08/%h", c, out_valid, out_d[3], w);
            end
            advance();
        end
        drive(1, 3'd1, x, 0, 8'hFF);
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready got=%b want=1", in_ready); end
        advance();
        drive(0, 3'd0, 32'h0, 0, 8'hFF);
        n_cmp++;
        if (out_valid !== 8'h02 || out_d[1] !== x) begin
            n_bad++; $display("FAIL bp_next got=%h/%h want=02/%h", out_valid, out_d[1], x);
        end
        advance();
    endtask

    task automatic test_handoff();
        drive(1, 3'd2, 32'h22222222, 0, 8'hFF);
        advance();
        drive(1, 3'd6, 32'h66666666, 0, 8'hFF);
        n_cmp++;
        if (out_valid !== 8'h04) begin n_bad++; $display("FAIL handoff_first got=%h want=04", out_valid); end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL handoff_ready got=%b want=1", in_ready); end
        advance();
        drive(0, 3'd0, 32'h0, 0, 8'hFF);
        n_cmp++;
        if (out_valid !== 8'h40 || out_d[6] !== 32'h66666666) begin
            n_bad++; $display("FAIL handoff_second got=%h/%h want=40/66666666", out_valid, out_d[6]);
        end
        advance();
    endtask

`ifdef DEMUX8_BROADCAST_EN
    task automatic test_broadcast();
        int seen [8];
        for (int i = 0; i < 8; i++) seen[i] = 0;
        drive(1, 3'd2, 32'h1234, 1, 8'hFF);
        advance();
        for (int j = 0; j < 8; j++) begin
            drive(0, 3'd0, 32'h0, 0, 8'h01 << j);
            n_cmp++;
            if (in_ready !== (j == 7)) begin n_bad++; $display("FAIL bcast_ready j=%0d got=%b", j, in_ready); end
            for (int i = 0; i < 8; i++)
                if (out_valid[i] && out_ready[i] && out_d[i] === 32'h1234) seen[i]++;
            advance();
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (seen[i] !== 1) begin n_bad++; $display("FAIL bcast_seen ch=%0d got=%0d want=1", i, seen[i]); end
        end
        n_cmp++;
        if (out_valid !== 8'h00) begin n_bad++; $display("FAIL bcast_done got=%h want=00", out_valid); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 9) == 0, 8'($urandom) | 8'($urandom));
            n_cmp++;
            if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_ready c=%0d got=%b want=%b", c, in_ready, exp_rdy); end
            n_cmp++;
            if (out_valid !== exp_valid) begin n_bad++; $display("FAIL rand_valid c=%0d got=%h want=%h", c, out_valid, exp_valid); end
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (out_d[i] !== exp_out[i]) begin
                    n_bad++; $display("FAIL rand_out c=%0d ch=%0d got=%h want=%h", c, i, out_d[i], exp_out[i]);
                end
            end
            advance();
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        sel_d     = 3'd0;
        in_d      = '0;
        bcast_d   = 1'b0;
        out_ready = 8'hFF;
        rst_n     = 1'b0;
        model_clear();
        #2;
        test_reset();
        test_single_route();
        test_streaming();
        test_back_pressure();
        test_handoff();
`ifdef DEMUX8_BROADCAST_EN
        test_broadcast();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/_demux8_reg.md
# _demux8_reg

Registered 1-to-8 demultiplexer with valid/ready handshakes. It is the distribution-side counterpart of the 8-input mux: one upstream producer sends a word tagged with a 3-bit destination, and the block forwards it to exactly one of eight consumers. It sits between the CPU datapath and per-unit sinks such as register-file write ports and functional-unit operand queues. A single holding register decouples upstream from downstream and gives full throughput while consumers keep up.

## Interface
Parameters:
- `n`, default `constants::WORD_LENGTH`: data width in bits.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `in_valid`, input, 1: upstream word present.
- `in_ready`, output, 1: block accepts the word this cycle.
- `sel`, input, 3: destination channel, 0..7; sampled with `in`.
- `in`, input, n: data word.
- `bcast`, input, 1: broadcast request. Present only with `DEMUX8_BROADCAST_EN`.
- `out`, output, n × [7:0]: per-channel data.
- `out_valid`, output, 8: per-channel valid.
- `out_ready`, input, 8: per-channel consumer ready.

## Operation
- Internal state:
  - `data_q[n-1:0]`: held word.
  - `pend_q[7:0]`: channels still owed the held word.
- State machine, derived from `pend_q`:
  - **EMPTY**: `pend_q == 0`.
  - **HOLD**: `pend_q != 0`.
- Outputs:
  - `out_valid = pend_q`.
  - `out[i] = data_q` when `pend_q[i]`, otherwise 0.
- Drain: a channel is done in a cycle when `pend_q[i] & out_ready[i]`. Define `drain = pend_q & ~out_ready`, the channels still owed after this cycle.
- Ready: `in_ready = (drain == 0)`. It is combinational and depends on `out_ready`, with no combinational path from `in_valid`. In EMPTY, `in_ready = 1`.
- Accept: when `in_valid & in_ready`:
  - `data_q <= in`.
  - `pend_q <= (1 << sel)`.
- No accept: `pend_q <= drain`, and `data_q` holds its value.
- Simultaneous drain of the last owed channel and a new accept is legal. The new word is loaded in the same edge, so there is no bubble.
- Channel `i` is never valid for a word whose `sel != i`.
- Reset mid-transfer: the held word is discarded. `pend_q = 0` immediately and asynchronously, and the word is not replayed.
- `sel` and `in` are don't-care when `in_valid = 0`.

## Timing
- Reset values: `pend_q = 0`, `data_q = 0`, `out_valid = 8'h00`, all `out[i] = 0`, `in_ready = 1`.
- Latency: a word accepted at edge k drives `out_valid[sel]` from cycle k+1.
- Throughput: 1 word/cycle when the destination `out_ready` is high.
- Back-pressure:
  - `in_ready` falls in the same cycle a pending channel's `out_ready` is low.
  - Held `out`/`out_valid` stay stable until `out_ready` is seen.
- Upstream rule: `in`/`sel` may change freely while `in_ready = 0`. Only the accept cycle is sampled.
- Downstream rule: a consumer may assert `out_ready` at any time, including before `out_valid`.

## Configuration
- Macro: `DEMUX8_BROADCAST_EN`.
- **Defined:**
  - The `bcast` port exists.
  - An accept with `bcast = 1` loads `pend_q <= 8'hFF` and ignores `sel`.
  - The word is held until every channel has accepted; channels drain independently, in any order, across cycles.
  - `in_ready` stays low until the last channel drains. The same-cycle reload rule still applies.
- **Undefined:**
  - There is no `bcast` port.
  - `pend_q` is always one-hot or zero.
  - The `pend_q` register may reduce to a valid bit plus a 3-bit index. Behaviour at the ports is identical.

## Structure
- Shared package `constants`:
  - `WORD_LENGTH` (existing).
  - `DEMUX8_WAYS = 8`.
  - `typedef logic [2:0] sel8_t`.
- One sub-module, `_dec3to8`: a combinational 3-to-8 one-hot decoder from `sel` to a mask. It is reused for the accept mask and is available to other utilities.
- Outputs use the same unpacked-array convention as the mux's `in [7:0]`.

## Test plan
- Reset: assert `rst_n = 0` mid-HOLD with `pend_q = 8'h10` → `out_valid = 0` and `out[4] = 0` immediately. After release, `in_ready = 1`.
- Single route: `in = 32'hDEADBEEF`, `sel = 5`, all `out_ready = 1` → next cycle `out_valid = 8'h20` and `out[5] = 32'hDEADBEEF`; every other `out[i] = 0`.
- Streaming: 16 back-to-back words with `sel` cycling 0..7 and all ready → one word per cycle, in order, to the correct channel, with no bubbles.
- Back-pressure: `sel = 3`, `out_ready[3] = 0` for 4 cycles → `in_ready = 0` and `out[3]` stable all 4 cycles. The next word is accepted in the same cycle `out_ready[3]` rises.
- Same-cycle handoff: HOLD on channel 2 with `out_ready[2] = 1` and `in_valid` for `sel = 6` → `out_valid` goes `8'h04` then `8'h40` on consecutive cycles.
- Broadcast (macro defined): `bcast = 1`, `in = 32'h1234`. Channels 0..7 become ready one per cycle → `in_ready` stays 0 for 7 cycles and rises with the last ready. Each channel sees `32'h1234` exactly once.
